pipelined_prefix_subtractor_32: RTL and testbench
=================================================

# pipelined_prefix_subtractor_32

Pipelined parallel-prefix (Kogge-Stone) subtractor computing `A - B - Bin` with borrow-out, fully registered per prefix level. It is the arithmetic counterpart to the team's pipelined prefix adder and shares its propagate/generate datapath structure. It adds a valid/ready handshake on both ends so it can sit in a stream between producer and consumer stages with backpressure.

## Interface
- `WIDTH`, 32, operand width; power of two, 8..64; prefix levels `L = log2(WIDTH)`.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operand beat valid.
- `in_ready`  output  1  block accepts beat this cycle.
- `A`  input  WIDTH  minuend.
- `B`  input  WIDTH  subtrahend.
- `Bin`  input  1  borrow-in.
- `out_valid`  output  1  result beat valid.
- `out_ready`  input  1  consumer accepts result.
- `Diff`  output  WIDTH  `A - B - Bin` mod 2^WIDTH.
- `Bout`  output  1  borrow-out; 1 when unsigned `A < B + Bin`.
- `Ovf`  output  1  signed overflow (only with `PFX_SUB_FLAGS_EN`, else tied 0).
- `Eq`  output  1  `Diff == 0` (only with `PFX_SUB_FLAGS_EN`, else tied 0).
- `Lts`  output  1  signed `A < B + Bin` (only with `PFX_SUB_FLAGS_EN`, else tied 0).

## Operation
- Subtraction is computed as `A + ~B + ~Bin`; the carry chain uses `Cin' = ~Bin` and `Bout = ~Cout`.
- Stage 1 registers `P = A ^ ~B`, `G = A & ~B`, `Cin'`, and the sign bits `A[W-1]` and `~B[W-1]`.
- Stages 2..L+1 each register one Kogge-Stone level with span 1, 2, 4, ... 2^(L-1):
  - `G[i] = G[i] | P[i] & G[i-s]`
  - `P[i] = P[i] & P[i-s]`
  - Bits `i < s` pass through unchanged.
  - The original P vector and `Cin'` travel alongside.
- Stage L+2 forms the carries `C[i] = Gpre[i-1] | Ppre[i-1] & Cin'`, with `C[0] = Cin'`. It registers:
  - `Diff = Porig ^ C[W-1:0]`
  - `Bout = ~C[W]`
  - the optional flags.
- Each stage carries a valid bit. Stage registers load only when global enable `en = ~out_valid | out_ready`.
- `in_ready = en`. A beat is accepted when `in_valid & in_ready`. When not accepted, the stage-1 valid bit loads 0 on `en`, creating a bubble.
- On stall (`en = 0`), every stage holds its data and valid. Outputs are stable until the handshake completes.
- Results emerge strictly in acceptance order. There is no drop and no duplication.
- Flags:
  - `Ovf = (A[W-1] != B[W-1]) & (Diff[W-1] != A[W-1])`.
  - `Eq = ~|Diff`.
  - `Lts = Diff[W-1] ^ Ovf`.

## Timing
- Latency is L+2 cycles from an accepted beat to `out_valid` (7 for WIDTH=32) when unstalled.
- Throughput is one beat per cycle when `out_ready` is held high.
- Reset values: all stage valid bits, `out_valid`, `Diff`, `Bout`, `Ovf`, `Eq`, `Lts` are 0. `in_ready` is 1 during and after reset.
- Reset mid-operation: assertion clears all in-flight beats immediately (asynchronous). They are lost, not replayed. The first accept is possible on the first rising edge after deassertion.
- Simultaneous output handshake and input accept in the same cycle: both occur and the pipeline advances one position.
- `out_ready` low with `out_valid` low does not stall; bubbles collapse only through the output stage.
- `in_ready` depends combinationally on `out_ready`. There is no combinational path from `in_valid` to `out_valid`.

## Configuration
- `PFX_SUB_FLAGS_EN` defined: the sign-bit pipeline and the `Ovf`/`Eq`/`Lts` logic and registers are present and operate as described above.
- `PFX_SUB_FLAGS_EN` undefined: the sign-bit pipeline and flag registers are removed, and `Ovf`, `Eq`, `Lts` are constant 0. `Diff`, `Bout`, handshake and latency are unchanged.

## Test plan
- Input `A=5`, `B=3`, `Bin=0`, `out_ready=1` -> `out_valid` exactly 7 cycles later with `Diff=2`, `Bout=0`, `Eq=0`.
- Input `A=0`, `B=1`, `Bin=0` -> `Diff=0xFFFFFFFF`, `Bout=1`, `Ovf=0`, `Lts=1`.
- Input `A=0x80000000`, `B=1`, `Bin=0` -> `Diff=0x7FFFFFFF`, `Bout=0`, `Ovf=1`, `Lts=1`. Without the macro, `Ovf=0`.
- Input `A=10`, `B=9`, `Bin=1` -> `Diff=0`, `Eq=1`, `Bout=0`. Then `A=10`, `B=10`, `Bin=1` -> `Diff=0xFFFFFFFF`, `Bout=1`.
- Stream 20 random beats while toggling `out_ready` with a 3-on/2-off pattern -> all 20 results in order and matching the reference model. `in_ready=0` in exactly the cycles where `out_valid=1` and `out_ready=0`. Outputs are stable while stalled.
- Accept 4 beats, then assert `reset` for 1 cycle before any output -> `out_valid` drops to 0 at once, no stale beat appears afterward, and a new beat of 7-2 yields `Diff=5` 7 cycles after acceptance.

Source files
------------

// File: rtl/pipelined_prefix_subtractor_32.sv
// Kogge-Stone subtractor A - B - Bin, one register stage per prefix level, valid/ready stream on both ends.
// Define PFX_SUB_FLAGS_EN to add the registered Ovf/Eq/Lts flags; otherwise those outputs are tied to 0.
module pipelined_prefix_subtractor_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Eq,
    output logic             Lts
);

    localparam int L = $clog2(WIDTH);

    logic             en;
    logic [L:0]       validD, validQ;
    logic [L:0]       cinD, cinQ;
    logic [WIDTH-1:0] pD     [0:L];
    logic [WIDTH-1:0] pQ     [0:L];
    logic [WIDTH-1:0] gD     [0:L];
    logic [WIDTH-1:0] gQ     [0:L];
    logic [WIDTH-1:0] pOrigD [0:L];
    logic [WIDTH-1:0] pOrigQ [0:L];

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] diffD, diffQ;
    logic             boutD, boutQ;
    logic             outValidQ;

    // The whole pipeline advances together; it only freezes when a result is waiting on the consumer.
    assign en       = ~outValidQ | out_ready;
    assign in_ready = en;

    always_comb begin
        validD[0] = in_valid;
        cinD[0]   = ~Bin;
        pD[0]     = A ^ ~B;
        gD[0]     = A & ~B;
        pOrigD[0] = A ^ ~B;
        for (int k = 1; k <= L; k++) begin
            validD[k] = validQ[k-1];
            cinD[k]   = cinQ[k-1];
            pOrigD[k] = pOrigQ[k-1];
            // Low bits (i < span) see an all-ones mask so P passes through; G gets zero-filled shift.
            pD[k] = pQ[k-1] & ((pQ[k-1] << (1 << (k-1)))
                               | ((WIDTH'(1) << (1 << (k-1))) - WIDTH'(1)));
            gD[k] = gQ[k-1] | (pQ[k-1] & (gQ[k-1] << (1 << (k-1))));
        end
    end

    assign carry = {gQ[L] | (pQ[L] & {WIDTH{cinQ[L]}}), cinQ[L]};
    assign diffD = pOrigQ[L] ^ carry[WIDTH-1:0];
    assign boutD = ~carry[WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validQ    <= '0;
            cinQ      <= '0;
            outValidQ <= 1'b0;
            diffQ     <= '0;
            boutQ     <= 1'b0;
            for (int k = 0; k <= L; k++) begin
                pQ[k]     <= '0;
                gQ[k]     <= '0;
                pOrigQ[k] <= '0;
            end
        end else if (en) begin
            validQ    <= validD;
            cinQ      <= cinD;
            outValidQ <= validQ[L];
            diffQ     <= diffD;
            boutQ     <= boutD;
            for (int k = 0; k <= L; k++) begin
                pQ[k]     <= pD[k];
                gQ[k]     <= gD[k];
                pOrigQ[k] <= pOrigD[k];
            end
        end
    end

    assign out_valid = outValidQ;
    assign Diff      = diffQ;
    assign Bout      = boutQ;

`ifdef PFX_SUB_FLAGS_EN
    logic [L:0] signAD, signAQ;
    logic [L:0] signNbD, signNbQ;
    logic       ovfD, ovfQ;
    logic       eqD, eqQ;
    logic       ltsD, ltsQ;

    always_comb begin
        signAD[0]  = A[WIDTH-1];
        signNbD[0] = ~B[WIDTH-1];
        for (int k = 1; k <= L; k++) begin
            signAD[k]  = signAQ[k-1];
            signNbD[k] = signNbQ[k-1];
        end
    end

    // A and B have differing signs exactly when A's sign equals the inverted B sign.
    assign ovfD = (signAQ[L] == signNbQ[L]) & (diffD[WIDTH-1] != signAQ[L]);
    assign eqD  = ~|diffD;
    assign ltsD = diffD[WIDTH-1] ^ ovfD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            signAQ  <= '0;
            signNbQ <= '0;
            ovfQ    <= 1'b0;
            eqQ     <= 1'b0;
            ltsQ    <= 1'b0;
        end else if (en) begin
            signAQ  <= signAD;
            signNbQ <= signNbD;
            ovfQ    <= ovfD;
            eqQ     <= eqD;
            ltsQ    <= ltsD;
        end
    end

    assign Ovf = ovfQ;
    assign Eq  = eqQ;
    assign Lts = ltsQ;
`else
    assign Ovf = 1'b0;
    assign Eq  = 1'b0;
    assign Lts = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_prefix_subtractor_32.sv
// Scoreboard bench for pipelined_prefix_subtractor_32: directed cases, backpressured stream, mid-flight resets.
// Flag expectations follow PFX_SUB_FLAGS_EN the same way the design does.
module tb_pipelined_prefix_subtractor_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic        binIn;
    logic        outValid;
    logic        outReady;
    logic [31:0] diffOut;
    logic        boutOut;
    logic        ovfOut;
    logic        eqOut;
    logic        ltsOut;

    typedef struct packed {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        logic        eq;
        logic        lts;
        int          acc;
    } expT;

    expT         sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cycleNum = 0;
    int          acceptedCount = 0;
    bit          checkLat;
    bit          prevStall;
    logic [31:0] prevDiff;
    logic        prevBout;

    pipelined_prefix_subtractor_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .A         (aIn),
        .B         (bIn),
        .Bin       (binIn),
        .out_valid (outValid),
        .out_ready (outReady),
        .Diff      (diffOut),
        .Bout      (boutOut),
        .Ovf       (ovfOut),
        .Eq        (eqOut),
        .Lts       (ltsOut)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, observed, expected, cycleNum);
        end
    endtask

    function automatic expT model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        expT         e;
        logic [32:0] ext;
        ext    = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        e.diff = ext[31:0];
        e.bout = ext[32];
        e.acc  = 0;
`ifdef PFX_SUB_FLAGS_EN
        e.ovf  = (a[31] != b[31]) && (e.diff[31] != a[31]);
        e.eq   = (e.diff == 32'd0);
        e.lts  = e.diff[31] ^ e.ovf;
`else
        e.ovf  = 1'b0;
        e.eq   = 1'b0;
        e.lts  = 1'b0;
`endif
        return e;
    endfunction

    // Called at posedge+1: drives one cycle, checks at posedge+3, returns at the next posedge+1.
    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic bin, input logic ordy);
        expT e;
        inValid  = v;
        aIn      = a;
        bIn      = b;
        binIn    = bin;
        outReady = ordy;
        #2;
        checkOutput("in_ready", {63'd0, inReady}, {63'd0, !(outValid && !ordy)});
        if (prevStall) begin
            checkOutput("stall_valid", {63'd0, outValid}, 64'd1);
            checkOutput("stall_diff", {32'd0, diffOut}, {32'd0, prevDiff});
            checkOutput("stall_bout", {63'd0, boutOut}, {63'd0, prevBout});
        end
        if (outValid && ordy) begin
            if (sb.size() == 0) begin
                checkOutput("stale_beat", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("diff", {32'd0, diffOut}, {32'd0, e.diff});
                checkOutput("bout", {63'd0, boutOut}, {63'd0, e.bout});
                checkOutput("ovf", {63'd0, ovfOut}, {63'd0, e.ovf});
                checkOutput("eq", {63'd0, eqOut}, {63'd0, e.eq});
                checkOutput("lts", {63'd0, ltsOut}, {63'd0, e.lts});
                if (checkLat)
                    checkOutput("latency", 64'(cycleNum - e.acc), 64'd7);
            end
        end
        if (v && inReady) begin
            e     = model(a, b, bin);
            e.acc = cycleNum;
            sb.push_back(e);
            acceptedCount++;
        end
        prevStall = outValid && !ordy;
        prevDiff  = diffOut;
        prevBout  = boutOut;
        @(posedge clk);
        #1;
        cycleNum++;
    endtask

    task automatic resetPulse();
        inValid = 1'b0;
        reset   = 1'b0;
        #1;
        checkOutput("rst_valid", {63'd0, outValid}, 64'd0);
        checkOutput("rst_ready", {63'd0, inReady}, 64'd1);
        checkOutput("rst_diff", {32'd0, diffOut}, 64'd0);
        checkOutput("rst_bout", {63'd0, boutOut}, 64'd0);
        sb.delete();
        prevStall = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycleNum++;
    endtask

    task automatic drain(input bit toggled);
        for (int i = 0; i < 40; i++)
            applyStimulus(1'b0, $urandom, $urandom, 1'b0, toggled ? ((cycleNum % 5) < 3) : 1'b1);
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        reset     = 1'b0;
        inValid   = 1'b0;
        aIn       = '0;
        bIn       = '0;
        binIn     = 1'b0;
        outReady  = 1'b1;
        prevStall = 1'b0;
        prevDiff  = '0;
        prevBout  = 1'b0;
        checkLat  = 1'b1;
        #3;
        checkOutput("reset_valid", {63'd0, outValid}, 64'd0);
        checkOutput("reset_ready", {63'd0, inReady}, 64'd1);
        checkOutput("reset_diff", {32'd0, diffOut}, 64'd0);
        checkOutput("reset_flags", {61'd0, boutOut, ovfOut, ltsOut}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed corner cases, back to back with the consumer always ready.
        applyStimulus(1'b1, 32'd5, 32'd3, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'd0, 32'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'd10, 32'd9, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'd10, 32'd10, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
        drain(1'b0);

        // Random stream against a 3-on/2-off consumer.
        checkLat      = 1'b0;
        acceptedCount = 0;
        for (int c = 0; c < 300 && acceptedCount < 20; c++)
            applyStimulus($urandom_range(0, 4) != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
                          (cycleNum % 5) < 3);
        checkOutput("stream_accepted", 64'(acceptedCount), 64'd20);
        drain(1'b1);

        // Reset with four beats in flight, before any result appears.
        checkLat = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, $urandom, $urandom, 1'b0, 1'b1);
        resetPulse();
        applyStimulus(1'b1, 32'd7, 32'd2, 1'b0, 1'b1);
        drain(1'b0);

        // Reset while a result is stalled at the output.
        checkLat = 1'b0;
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        checkOutput("stalled_valid", {63'd0, outValid}, 64'd1);
        resetPulse();
        drain(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
